// File: rtl/tx_write_arbiter.sv
// Round-robin arbiter sharing the TX FIFO write port between the CPU word path and the DMA burst path.
// Optional statistics counters (words_wr, stall_cyc) are enabled by defining TXARB_STATS_EN.
module tx_write_arbiter #(
    parameter int WIDTH = 32,
    parameter int BURST = 4,
    parameter int CNTW  = 16
) (
    input  logic             wclk,
    input  logic             rst_,
    input  logic             enable,
    input  logic             cpu_req,
    input  logic [WIDTH-1:0] cpu_data,
    output logic             cpu_ack,
    input  logic             dma_req,
    input  logic [WIDTH-1:0] dma_data,
    output logic             dma_ack,
    output logic             dma_done,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [WIDTH-1:0] fifo_din,
    output logic             ch_next,
    output logic             busy
`ifdef TXARB_STATS_EN
    ,
    output logic [CNTW-1:0]  words_wr,
    output logic [CNTW-1:0]  stall_cyc
`endif
);

    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        GNT_CPU = 2'd1,
        GNT_DMA = 2'd2
    } state_t;

    state_t        state_q;
    logic          last_dma_q;
    logic [BW-1:0] beat_q;
    logic          done_q;
    logic          ch_q, ch_d;
    logic          xfer_cpu, xfer_dma;

    always_comb begin
        xfer_cpu   = (state_q == GNT_CPU) && cpu_req && !fifo_full && enable;
        xfer_dma   = (state_q == GNT_DMA) && dma_req && !fifo_full && enable;
        fifo_wr_en = xfer_cpu || xfer_dma;
        fifo_din   = '0;
        if (xfer_cpu) begin
            fifo_din = cpu_data;
        end else if (xfer_dma) begin
            fifo_din = dma_data;
        end
    end

    assign cpu_ack  = xfer_cpu;
    assign dma_ack  = xfer_dma;
    assign dma_done = done_q;
    assign busy     = (state_q != ARB);
    assign ch_next  = ch_q && enable;

    // last_dma_q=1 means DMA won most recently, so the CPU wins the next tie.
    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= ARB;
            last_dma_q <= 1'b1;
            beat_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ARB: begin
                    if (enable) begin
                        if (cpu_req && (!dma_req || last_dma_q)) begin
                            state_q <= GNT_CPU;
                        end else if (dma_req) begin
                            state_q <= GNT_DMA;
                            beat_q  <= '0;
                        end
                    end
                end
                GNT_CPU: begin
                    if (xfer_cpu) begin
                        state_q    <= ARB;
                        last_dma_q <= 1'b0;
                    end else if (!enable) begin
                        state_q <= ARB;
                    end
                end
                GNT_DMA: begin
                    if (!enable || !dma_req) begin
                        state_q <= ARB;
                        done_q  <= 1'b1;
                    end else if (xfer_dma) begin
                        if (beat_q == LAST_BEAT) begin
                            state_q    <= ARB;
                            last_dma_q <= 1'b1;
                            done_q     <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    always_comb begin
        ch_d = ch_q;
        if (!enable) begin
            ch_d = 1'b0;
        end else if (fifo_wr_en) begin
            ch_d = !ch_q;
        end
    end

    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            ch_q <= 1'b0;
        end else begin
            ch_q <= ch_d;
        end
    end

`ifdef TXARB_STATS_EN
    logic [CNTW-1:0] words_q, words_d;
    logic [CNTW-1:0] stall_q, stall_d;
    logic            stall_now;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        stall_now = fifo_full &&
                    (((state_q == GNT_CPU) && cpu_req) || ((state_q == GNT_DMA) && dma_req));
        words_d = words_q;
        stall_d = stall_q;
        if (!enable) begin
            words_d = '0;
            stall_d = '0;
        end else begin
            if (fifo_wr_en) words_d = sat_inc(words_q);
            if (stall_now)  stall_d = sat_inc(stall_q);
        end
    end

    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            words_q <= '0;
            stall_q <= '0;
        end else begin
            words_q <= words_d;
            stall_q <= stall_d;
        end
    end

    assign words_wr  = words_q;
    assign stall_cyc = stall_q;
`endif

endmodule
